// File: rtl/input_debouncer.sv
// input_debouncer: two-flop synchroniser plus a four-state qualifier producing a clean level, settling flag and edge pulses.
// Rise/fall pulse logic exists only when DEBOUNCE_EDGE_PULSE_EN is defined; otherwise both are tied low.
module input_debouncer #(
    parameter int   STABLE_CYCLES = 4,
    parameter int   CNT_W         = 3,
    parameter logic RESET_LEVEL   = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d_raw,
    output logic q,
    output logic rise,
    output logic fall,
    output logic settling
);
    typedef enum logic [1:0] {STABLE_LO, CHECK_HI, STABLE_HI, CHECK_LO} state_t;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_CYCLES - 1);
    state_t           state;
    logic             sync1, sync2;
    logic [CNT_W-1:0] cnt;
`ifndef DEBOUNCE_EDGE_PULSE_EN
    assign rise = 1'b0;
    assign fall = 1'b0;
`endif
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1    <= RESET_LEVEL;
            sync2    <= RESET_LEVEL;
            q        <= RESET_LEVEL;
            settling <= 1'b0;
            cnt      <= '0;
            state    <= RESET_LEVEL ? STABLE_HI : STABLE_LO;
`ifdef DEBOUNCE_EDGE_PULSE_EN
            rise     <= 1'b0;
            fall     <= 1'b0;
`endif
        end else begin
            sync1 <= d_raw;
            sync2 <= sync1;
`ifdef DEBOUNCE_EDGE_PULSE_EN
            rise  <= 1'b0;
            fall  <= 1'b0;
`endif
            case (state)
                STABLE_LO: if (sync2) begin
                    state    <= CHECK_HI;
                    cnt      <= CNT_W'(1);
                    settling <= 1'b1;
                end
                CHECK_HI: if (!sync2) begin
                    state    <= STABLE_LO;
                    cnt      <= '0;
                    settling <= 1'b0;
                end else if (cnt == LAST) begin
                    state    <= STABLE_HI;
                    q        <= 1'b1;
                    cnt      <= '0;
                    settling <= 1'b0;
`ifdef DEBOUNCE_EDGE_PULSE_EN
                    rise     <= 1'b1;
`endif
                end else begin
                    cnt <= cnt + 1'b1;
                end
                STABLE_HI: if (!sync2) begin
                    state    <= CHECK_LO;
                    cnt      <= CNT_W'(1);
                    settling <= 1'b1;
                end
                default: if (sync2) begin
                    state    <= STABLE_HI;
                    cnt      <= '0;
                    settling <= 1'b0;
                end else if (cnt == LAST) begin
                    state    <= STABLE_LO;
                    q        <= 1'b0;
                    cnt      <= '0;
                    settling <= 1'b0;
`ifdef DEBOUNCE_EDGE_PULSE_EN
                    fall     <= 1'b1;
`endif
                end else begin
                    cnt <= cnt + 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_input_debouncer.sv
// tb_input_debouncer: directed plan cases then random bursts, checked every cycle against a run-length model.
// Pulse expectations follow DEBOUNCE_EDGE_PULSE_EN; without it rise/fall must stay 0.
module tb_input_debouncer;
    localparam int   SC = 4;
    localparam logic RL = 1'b0;
    logic clk = 1'b0, rst = 1'b1, d_raw = 1'b0;
    logic q, rise, fall, settling;
    int compared = 0, mismatched = 0;
    logic m_sh1 = RL, m_sh2 = RL, m_q = RL, m_rise = 1'b0, m_fall = 1'b0;
    int   m_run = 0;

    input_debouncer #(.STABLE_CYCLES(SC), .CNT_W(3), .RESET_LEVEL(RL)) dut (
        .clk(clk), .rst(rst), .d_raw(d_raw),
        .q(q), .rise(rise), .fall(fall), .settling(settling)
    );

    always #10 clk = ~clk;

    task automatic check(input string tag, input logic obs, input logic exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%b expected=%b at %0t", tag, obs, exp, $time);
        end
    endtask

    // The FSM sees the input two edges late; q flips once SC consecutive samples disagree with it.
    task automatic model_edge(input logic r, input logic d);
        logic s;
        m_rise = 1'b0;
        m_fall = 1'b0;
        if (r) begin
            m_sh1 = RL; m_sh2 = RL; m_q = RL; m_run = 0;
        end else begin
            s = m_sh2;
            m_sh2 = m_sh1;
            m_sh1 = d;
            if (s != m_q) begin
                m_run++;
                if (m_run == SC) begin
                    m_q = s;
                    m_run = 0;
                    m_rise = s;
                    m_fall = !s;
                end
            end else begin
                m_run = 0;
            end
        end
    endtask

    task automatic step(input string tag, input logic d, input logic r);
        @(negedge clk);
        d_raw = d;
        rst = r;
        @(posedge clk);
        model_edge(r, d);
        #1;
        check({tag, ".q"}, q, m_q);
        check({tag, ".settling"}, settling, m_run > 0);
`ifdef DEBOUNCE_EDGE_PULSE_EN
        check({tag, ".rise"}, rise, m_rise);
        check({tag, ".fall"}, fall, m_fall);
`else
        check({tag, ".rise"}, rise, 1'b0);
        check({tag, ".fall"}, fall, 1'b0);
`endif
    endtask

    initial begin
        for (int i = 0; i < 3; i++) step("reset_hold", 1'b1, 1'b1);
        for (int i = 0; i < 10; i++) step("post_reset_rise", 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) step("clean_fall", 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step("glitch_hi", 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) step("glitch_lo", 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) step("clean_rise", 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) step("clean_fall2", 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step("mid_check", 1'b1, 1'b0);
        step("mid_check_rst", 1'b1, 1'b1);
        for (int i = 0; i < 10; i++) step("after_rst", 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) step("to_low", 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) step("bounce", logic'(i[0]), 1'b0);
        for (int i = 0; i < 10; i++) step("bounce_hold", 1'b1, 1'b0);
        for (int b = 0; b < 60; b++) begin
            logic lvl;
            int   len;
            lvl = logic'($urandom_range(1));
            len = $urandom_range(SC + 4, 1);
            for (int i = 0; i < len; i++)
                step("random", lvl, $urandom_range(39) == 0);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
